// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: synchronizes the raw PS/2 clock and data lines,
// deframes 11-bit frames (start, 8 data LSB-first, odd parity, stop) and
// folds the F0 (break) and E0 (extended) prefixes into flags that are
// reported together with the final scancode.
//
// state  | meaning
// IDLE   | waiting for a start bit (data low on a falling PS/2 clock)
// DATA   | shifting in the eight data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | sampling the stop bit and judging the byte
module ps2_key_rx #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       key_break,
  output logic       key_ext,
  output logic       rx_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t           state;
  logic             clk_meta;
  logic             clk_s;
  logic             dat_meta;
  logic             dat_s;
  logic             clk_prev;
  logic             fall;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;
  logic             parity_bit;
  logic             break_pending;
  logic             ext_pending;
  logic [CNT_W-1:0] to_cnt;
  logic             timeout_hit;
  logic             frame_ok;

  // Two-flop synchronizers; reset to the idle (high) line level.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clk_meta <= 1'b1;
      clk_s    <= 1'b1;
      dat_meta <= 1'b1;
      dat_s    <= 1'b1;
    end else begin
      clk_meta <= PS2_CLK;
      clk_s    <= clk_meta;
      dat_meta <= PS2_DAT;
      dat_s    <= dat_meta;
    end
  end

  // Previous synchronized clock level, for falling-edge detection.
  always_ff @(posedge CLOCK_50) begin
    if (reset) clk_prev <= 1'b1;
    else       clk_prev <= clk_s;
  end

  assign fall = clk_prev & ~clk_s;

  // An edge in the same cycle as an expiring count takes priority.
  assign timeout_hit = (state != IDLE) && !fall && (to_cnt == CNT_LIMIT);

  // Stop bit must be high and data plus parity must hold an odd number of ones.
  assign frame_ok = dat_s & (^{shift_reg, parity_bit});

  // Mid-frame idle counter: restarts on every edge, idles at zero in IDLE.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (fall || (state == IDLE) || timeout_hit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + CNT_W'(1);
    end
  end

  // Frame FSM, prefix tracking and registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      parity_bit    <= 1'b0;
      break_pending <= 1'b0;
      ext_pending   <= 1'b0;
      key_code      <= '0;
      key_valid     <= 1'b0;
      key_break     <= 1'b0;
      key_ext       <= 1'b0;
      rx_err        <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      rx_err    <= 1'b0;
      if (fall) begin
        case (state)
          IDLE: begin
            if (!dat_s) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shift_reg <= {dat_s, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            parity_bit <= dat_s;
            state      <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!frame_ok) begin
              rx_err        <= 1'b1;
              break_pending <= 1'b0;
              ext_pending   <= 1'b0;
            end else if (shift_reg == 8'hF0) begin
              break_pending <= 1'b1;
            end else if (shift_reg == 8'hE0) begin
              ext_pending <= 1'b1;
            end else begin
              key_code      <= shift_reg;
              key_break     <= break_pending;
              key_ext       <= ext_pending;
              key_valid     <= 1'b1;
              break_pending <= 1'b0;
              ext_pending   <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (timeout_hit) begin
        state         <= IDLE;
        rx_err        <= 1'b1;
        break_pending <= 1'b0;
        ext_pending   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_rx.sv
// Directed bench for ps2_key_rx: table of whole frames with hand-computed
// results, plus hand-written latency, timeout and mid-frame reset sequences.
module tb_ps2_key_rx;

  localparam int TO   = 300;
  localparam int HALF = 15;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       PS2_CLK  = 1'b1;
  logic       PS2_DAT  = 1'b1;
  logic [7:0] key_code;
  logic       key_valid;
  logic       key_break;
  logic       key_ext;
  logic       rx_err;

  ps2_key_rx #(.TIMEOUT_CYCLES(TO)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .PS2_CLK  (PS2_CLK),
    .PS2_DAT  (PS2_DAT),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_break(key_break),
    .key_ext  (key_ext),
    .rx_err   (rx_err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int compared   = 0;
  int mismatched = 0;
  int n_valid    = 0;
  int n_err      = 0;
  int n_both     = 0;

  // Pulse counters, sampled away from the active edge.
  always @(negedge CLOCK_50) begin
    if (key_valid) n_valid++;
    if (rx_err) n_err++;
    if (key_valid && rx_err) n_both++;
  end

  typedef struct {
    logic [7:0] data;
    int         pflip;
    int         stop;
    int         exp_valid;
    int         exp_err;
    logic [7:0] exp_code;
    int         exp_brk;
    int         exp_ext;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input int pflip, input int stop);
    logic p;
    p = (~^d) ^ (pflip != 0);
    return {(stop != 0), p, d, 1'b0};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLOCK_50);
      PS2_DAT = f[i];
      idle(HALF);
      PS2_CLK = 1'b0;
      idle(HALF);
      PS2_CLK = 1'b1;
    end
  endtask

  vec_t vec[15];

  initial begin
    int v0, e0;

    vec[0]  = '{8'h1C, 0, 1, 1, 0, 8'h1C, 0, 0};
    vec[1]  = '{8'hF0, 0, 1, 0, 0, 8'h1C, 0, 0};
    vec[2]  = '{8'h1C, 0, 1, 1, 0, 8'h1C, 1, 0};
    vec[3]  = '{8'hE0, 0, 1, 0, 0, 8'h1C, 1, 0};
    vec[4]  = '{8'hF0, 0, 1, 0, 0, 8'h1C, 1, 0};
    vec[5]  = '{8'h75, 0, 1, 1, 0, 8'h75, 1, 1};
    vec[6]  = '{8'h1C, 1, 1, 0, 1, 8'h75, 1, 1};
    vec[7]  = '{8'h29, 0, 1, 1, 0, 8'h29, 0, 0};
    vec[8]  = '{8'hF0, 0, 1, 0, 0, 8'h29, 0, 0};
    vec[9]  = '{8'h1C, 0, 0, 0, 1, 8'h29, 0, 0};
    vec[10] = '{8'h29, 0, 1, 1, 0, 8'h29, 0, 0};
    vec[11] = '{8'hE0, 0, 1, 0, 0, 8'h29, 0, 0};
    vec[12] = '{8'h29, 0, 1, 1, 0, 8'h29, 0, 1};
    vec[13] = '{8'h00, 0, 1, 1, 0, 8'h00, 0, 0};
    vec[14] = '{8'hFF, 0, 1, 1, 0, 8'hFF, 0, 0};

    // Reset state
    idle(5);
    check("rst_key_code", key_code, 8'h00);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_break", key_break, 0);
    check("rst_key_ext", key_ext, 0);
    check("rst_rx_err", rx_err, 0);
    reset = 1'b0;
    idle(5);

    // Table-driven frames
    for (int i = 0; i < 15; i++) begin
      v0 = n_valid;
      e0 = n_err;
      send_bits(mk_frame(vec[i].data, vec[i].pflip, vec[i].stop), 11);
      idle(10);
      check($sformatf("vec%0d_valid_pulses", i), n_valid - v0, vec[i].exp_valid);
      check($sformatf("vec%0d_err_pulses", i), n_err - e0, vec[i].exp_err);
      check($sformatf("vec%0d_key_code", i), key_code, vec[i].exp_code);
      check($sformatf("vec%0d_key_break", i), key_break, vec[i].exp_brk);
      check($sformatf("vec%0d_key_ext", i), key_ext, vec[i].exp_ext);
    end

    // Latency: key_valid appears 3 cycles after the raw stop-bit clock fall
    send_bits(mk_frame(8'h5A, 0, 1), 10);
    @(negedge CLOCK_50);
    PS2_DAT = 1'b1;
    idle(HALF);
    PS2_CLK = 1'b0;
    @(negedge CLOCK_50);
    check("lat_cycle1", key_valid, 0);
    @(negedge CLOCK_50);
    check("lat_cycle2", key_valid, 0);
    @(negedge CLOCK_50);
    check("lat_cycle3", key_valid, 1);
    check("lat_key_code", key_code, 8'h5A);
    @(negedge CLOCK_50);
    check("lat_cycle4", key_valid, 0);
    idle(HALF - 4);
    PS2_CLK = 1'b1;
    idle(10);

    // Timeout after start + 4 data bits, with a break prefix pending
    send_bits(mk_frame(8'hF0, 0, 1), 11);
    idle(10);
    v0 = n_valid;
    e0 = n_err;
    send_bits(mk_frame(8'h29, 0, 1), 5);
    idle(TO + 60);
    check("to_err_pulses", n_err - e0, 1);
    check("to_valid_pulses", n_valid - v0, 0);
    v0 = n_valid;
    send_bits(mk_frame(8'h29, 0, 1), 11);
    idle(10);
    check("to_next_valid", n_valid - v0, 1);
    check("to_next_code", key_code, 8'h29);
    check("to_next_break", key_break, 0);

    // Reset after 5 bits, with a break prefix pending
    send_bits(mk_frame(8'hF0, 0, 1), 11);
    idle(10);
    v0 = n_valid;
    e0 = n_err;
    send_bits(mk_frame(8'h1C, 0, 1), 5);
    @(negedge CLOCK_50);
    reset = 1'b1;
    idle(2);
    check("mrst_key_code", key_code, 8'h00);
    check("mrst_key_valid", key_valid, 0);
    check("mrst_key_break", key_break, 0);
    check("mrst_key_ext", key_ext, 0);
    check("mrst_rx_err", rx_err, 0);
    reset = 1'b0;
    idle(TO + 60);
    check("mrst_err_pulses", n_err - e0, 0);
    check("mrst_valid_pulses", n_valid - v0, 0);
    send_bits(mk_frame(8'h1C, 0, 1), 11);
    idle(10);
    check("mrst_next_valid", n_valid - v0, 1);
    check("mrst_next_code", key_code, 8'h1C);
    check("mrst_next_break", key_break, 0);
    check("mrst_next_ext", key_ext, 0);

    check("valid_err_overlap", n_both, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
